// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU widths, requant command record and multiply helper
package npu_pkg;

    localparam int DATA_W      = 8;
    localparam int ACC_W       = 32;
    localparam int REQ_SCALE_W = 16;
    localparam int REQ_SHIFT_W = 5;
    localparam int REQ_DIM_W   = 16;
    localparam int REQ_SUM_W   = ACC_W + 1;
    localparam int REQ_PROD_W  = REQ_SUM_W + REQ_SCALE_W + 1;

    typedef struct packed {
        logic [REQ_DIM_W-1:0]   rows;
        logic [REQ_DIM_W-1:0]   cols;
        logic [REQ_DIM_W-1:0]   src_base;
        logic [REQ_DIM_W-1:0]   bias_base;
        logic [REQ_DIM_W-1:0]   dst_base;
        logic [REQ_SCALE_W-1:0] scale;
        logic [REQ_SHIFT_W-1:0] shift;
        logic                   bias_en;
    } req_cmd_t;

    // Signed sum times unsigned scale, widened so the product can never wrap.
    function automatic logic signed [REQ_PROD_W-1:0] req_mul(
        input logic signed [REQ_SUM_W-1:0] sum,
        input logic [REQ_SCALE_W-1:0]      scale
    );
        logic signed [REQ_PROD_W-1:0] a;
        logic signed [REQ_PROD_W-1:0] b;
        a = REQ_PROD_W'(sum);
        b = $signed({{(REQ_PROD_W-REQ_SCALE_W){1'b0}}, scale});
        return a * b;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - round-half-up right shift of a wide product, saturated to int8
module requant_sat
    import npu_pkg::*;
(
    input  logic signed [REQ_PROD_W-1:0] prod,
    input  logic [REQ_SHIFT_W-1:0]       shift,
    output logic [DATA_W-1:0]            q,
    output logic                         sat
);

    localparam int RES_W = REQ_PROD_W + 1;
    localparam logic signed [RES_W-1:0] SAT_HI = RES_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [RES_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [RES_W-1:0] half;
    logic signed [RES_W-1:0] rnd;
    logic signed [RES_W-1:0] res;

    always_comb begin
        half = '0;
        if (shift != '0) begin
            half = RES_W'(1) << (shift - 5'd1);
        end
        // One extra bit keeps prod + half exact before the arithmetic shift.
        rnd = RES_W'(prod) + half;
        res = rnd >>> shift;
        sat = 1'b0;
        q   = res[DATA_W-1:0];
        if (res > SAT_HI) begin
            q   = SAT_HI[DATA_W-1:0];
            sat = 1'b1;
        end else if (res < SAT_LO) begin
            q   = SAT_LO[DATA_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/requant_engine.sv
// rtl/requant_engine.sv - int32 accumulator tile to int8 requantizer (bias, scale, shift, clamp)
module requant_engine
    import npu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [REQ_DIM_W-1:0]   rows,
    input  logic [REQ_DIM_W-1:0]   cols,
    input  logic [REQ_DIM_W-1:0]   src_base,
    input  logic [REQ_DIM_W-1:0]   bias_base,
    input  logic [REQ_DIM_W-1:0]   dst_base,
    input  logic [REQ_SCALE_W-1:0] scale,
    input  logic [REQ_SHIFT_W-1:0] shift,
    input  logic                   bias_en,
    output logic                   rd_en,
    output logic [REQ_DIM_W-1:0]   rd_addr,
    input  logic [ACC_W-1:0]       rd_data,
    output logic                   wr_en,
    output logic [REQ_DIM_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [REQ_DIM_W-1:0]   sat_count,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_BIAS,
        S_RD_ACC,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    req_cmd_t                     cmd_q, cmd_d;
    logic [REQ_DIM_W-1:0]         col_q, col_d;
    logic [REQ_DIM_W-1:0]         row_q, row_d;
    logic [REQ_DIM_W-1:0]         lin_q, lin_d;
    logic [ACC_W-1:0]             bias_q, bias_d;
    logic signed [REQ_PROD_W-1:0] prod_q, prod_d;
    logic [REQ_DIM_W-1:0]         sat_count_q, sat_count_d;

    logic                         last_col;
    logic                         last_elem;
    logic signed [REQ_SUM_W-1:0]  sum;
    logic [DATA_W-1:0]            q_data;
    logic                         q_sat;

    requant_sat u_sat (
        .prod  (prod_q),
        .shift (cmd_q.shift),
        .q     (q_data),
        .sat   (q_sat)
    );

    assign last_col  = (col_q == cmd_q.cols - 16'd1);
    assign last_elem = last_col && (row_q == cmd_q.rows - 16'd1);
    // rd_data carries the accumulator in S_CALC; bias_q is zero when bias is disabled.
    assign sum       = $signed({rd_data[ACC_W-1], rd_data}) + $signed({bias_q[ACC_W-1], bias_q});
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign sat_count = sat_count_q;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        col_d       = col_q;
        row_d       = row_q;
        lin_d       = lin_q;
        bias_d      = bias_q;
        prod_d      = prod_q;
        sat_count_d = sat_count_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.rows      = rows;
                    cmd_d.cols      = cols;
                    cmd_d.src_base  = src_base;
                    cmd_d.bias_base = bias_base;
                    cmd_d.dst_base  = dst_base;
                    cmd_d.scale     = scale;
                    cmd_d.shift     = shift;
                    cmd_d.bias_en   = bias_en;
                    col_d           = '0;
                    row_d           = '0;
                    lin_d           = '0;
                    bias_d          = '0;
                    sat_count_d     = '0;
                    if (rows == '0 || cols == '0) begin
                        state_d = S_DONE;
                    end else if (bias_en) begin
                        state_d = S_RD_BIAS;
                    end else begin
                        state_d = S_RD_ACC;
                    end
                end
            end
            S_RD_BIAS: begin
                rd_en   = 1'b1;
                rd_addr = cmd_q.bias_base + col_q;
                state_d = S_RD_ACC;
            end
            S_RD_ACC: begin
                rd_en   = 1'b1;
                rd_addr = cmd_q.src_base + lin_q;
                bias_d  = cmd_q.bias_en ? rd_data : '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                prod_d  = req_mul(sum, cmd_q.scale);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = cmd_q.dst_base + lin_q;
                wr_data = q_data;
                if (q_sat && sat_count_q != 16'hFFFF) begin
                    sat_count_d = sat_count_q + 16'd1;
                end
                if (last_elem) begin
                    state_d = S_DONE;
                end else begin
                    lin_d = lin_q + 16'd1;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    state_d = cmd_q.bias_en ? S_RD_BIAS : S_RD_ACC;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lin_q       <= '0;
            bias_q      <= '0;
            prod_q      <= '0;
            sat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lin_q       <= lin_d;
            bias_q      <= bias_d;
            prod_q      <= prod_d;
            sat_count_q <= sat_count_d;
        end
    end

endmodule
